// File: rtl/vga_timing_gen.sv
// Raster timing generator with mixed-radix {hi,lo} x/y counters, registered
// sync and strobe outputs, a combinational blank and a wrapping frame counter.
module vga_timing_gen #(
  parameter int unsigned XH_W      = 6,
  parameter int unsigned XL_W      = 6,
  parameter int unsigned YH_W      = 5,
  parameter int unsigned YL_W      = 6,
  parameter int unsigned H_ROLL    = 39,
  parameter int unsigned V_ROLL    = 44,
  parameter int unsigned H_FPORCH  = 32*64,
  parameter int unsigned H_SYNC    = 33*64+8,
  parameter int unsigned H_BPORCH  = 34*64,
  parameter int unsigned H_NEXT    = 35*64+39,
  parameter int unsigned V_FPORCH  = 16*64,
  parameter int unsigned V_SYNC    = 16*64+3,
  parameter int unsigned V_BPORCH  = 16*64+8,
  parameter int unsigned V_NEXT    = 16*64+20,
  parameter logic        HSYNC_POL = 1'b1,
  parameter logic        VSYNC_POL = 1'b0,
  parameter int unsigned FETCH_X   = 35*64+31,
  parameter int unsigned FRAME_W   = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               pix_en,
  output logic [XH_W-1:0]    x_hi,
  output logic [XL_W-1:0]    x_lo,
  output logic [YH_W-1:0]    y_hi,
  output logic [YL_W-1:0]    y_lo,
  output logic               hsync,
  output logic               vsync,
  output logic               blank,
  output logic               line_start,
  output logic               frame_start,
  output logic               fetch,
  output logic [FRAME_W-1:0] frame_cnt
);

  localparam int unsigned XW = XH_W + XL_W;
  localparam int unsigned YW = YH_W + YL_W;

  localparam logic [XW-1:0]   X_FPORCH = XW'(H_FPORCH);
  localparam logic [XW-1:0]   X_SYNC   = XW'(H_SYNC);
  localparam logic [XW-1:0]   X_BPORCH = XW'(H_BPORCH);
  localparam logic [XW-1:0]   X_NEXT   = XW'(H_NEXT);
  localparam logic [XW-1:0]   X_FETCH  = XW'(FETCH_X);
  localparam logic [YW-1:0]   Y_FPORCH = YW'(V_FPORCH);
  localparam logic [YW-1:0]   Y_SYNC   = YW'(V_SYNC);
  localparam logic [YW-1:0]   Y_BPORCH = YW'(V_BPORCH);
  localparam logic [YW-1:0]   Y_NEXT   = YW'(V_NEXT);
  localparam logic [XL_W-1:0] X_ROLL   = XL_W'(H_ROLL);
  localparam logic [YL_W-1:0] Y_ROLL   = YL_W'(V_ROLL);

  logic [XW-1:0]   x;
  logic [YW-1:0]   y;
  logic [YW-1:0]   y_nxt;
  logic [YW-1:0]   y_inc;
  logic [XH_W-1:0] x_hi_nxt;
  logic [XL_W-1:0] x_lo_nxt;
  logic [YH_W-1:0] y_hi_nxt;
  logic [YL_W-1:0] y_lo_nxt;
  logic            x_wrap;
  logic            y_step;
  logic            y_wrap;

  assign x      = {x_hi, x_lo};
  assign y      = {y_hi, y_lo};
  assign y_nxt  = {y_hi_nxt, y_lo_nxt};
  assign y_inc  = y + YW'(1);
  assign x_wrap = (x == X_NEXT);
  assign y_step = (x == X_SYNC);
  assign y_wrap = y_step && (y == Y_NEXT);

  // The end-of-line wrap wins over the lo-field roll, which wins over +1.
  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    x_hi_nxt = x_hi;
    x_lo_nxt = x_lo + XL_W'(1);
    if (x_wrap) begin
      x_hi_nxt = '0;
      x_lo_nxt = '0;
    end else if (x_lo == X_ROLL) begin
      x_hi_nxt = x_hi + XH_W'(1);
      x_lo_nxt = '0;
    end

    y_hi_nxt = y_hi;
    y_lo_nxt = y_lo;
    if (y_wrap) begin
      y_hi_nxt = '0;
      y_lo_nxt = '0;
    end else if (y_step && (y_lo == Y_ROLL)) begin
      y_hi_nxt = y_hi + YH_W'(1);
      y_lo_nxt = '0;
    end else if (y_step) begin
      y_lo_nxt = y_lo + YL_W'(1);
    end
  end

  assign blank = (x >= X_FPORCH) || (y >= Y_FPORCH);

  // NOTE: state uses non-blocking assignments; reset is sampled on the clock
  // edge and overrides pix_en.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      x_hi        <= '0;
      x_lo        <= '0;
      y_hi        <= '0;
      y_lo        <= '0;
      frame_cnt   <= '0;
      hsync       <= ~HSYNC_POL;
      vsync       <= ~VSYNC_POL;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      fetch       <= 1'b0;
    end else if (pix_en) begin
      x_hi <= x_hi_nxt;
      x_lo <= x_lo_nxt;
      y_hi <= y_hi_nxt;
      y_lo <= y_lo_nxt;
      if (y_wrap) frame_cnt <= frame_cnt + FRAME_W'(1);
      hsync       <= ((x >= X_SYNC) && (x < X_BPORCH)) ? HSYNC_POL : ~HSYNC_POL;
      vsync       <= ((y >= Y_SYNC) && (y < Y_BPORCH)) ? VSYNC_POL : ~VSYNC_POL;
      line_start  <= x_wrap && (y_nxt < Y_FPORCH);
      frame_start <= x_wrap && (y == '0);
      // y has already stepped by FETCH_X, so it names the upcoming line.
      fetch       <= (x == X_FETCH) && ((y == Y_NEXT) || (y_inc < Y_FPORCH));
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a default 720p instance and a shrunken instance
// driven together and compared every cycle against a column/row index model.
module tb_vga_timing_gen;

  typedef struct {
    int xl_w, h_roll, h_fporch, h_sync, h_bporch, h_next, fetch_x;
    int yl_w, yw, v_roll, v_fporch, v_sync, v_bporch, v_next, frame_w;
    bit hpol, vpol;
  } cfg_t;

  // Position kept as a linear column/row index along the raster.
  typedef struct {
    int col, row, fcnt;
    bit hs, vs, ls, fs, fe;
  } model_t;

  logic clk = 1'b0;
  logic rst_n;
  logic pix_en;
  always #5 clk = ~clk;

  logic [5:0] d0_x_hi, d0_x_lo, d0_y_lo;
  logic [4:0] d0_y_hi;
  logic [7:0] d0_frame_cnt;
  logic d0_hsync, d0_vsync, d0_blank, d0_line_start, d0_frame_start, d0_fetch;

  logic [2:0] d1_x_hi, d1_x_lo, d1_y_hi, d1_frame_cnt;
  logic [1:0] d1_y_lo;
  logic d1_hsync, d1_vsync, d1_blank, d1_line_start, d1_frame_start, d1_fetch;

  vga_timing_gen u_dut_def (
    .clk(clk), .rst_n(rst_n), .pix_en(pix_en),
    .x_hi(d0_x_hi), .x_lo(d0_x_lo), .y_hi(d0_y_hi), .y_lo(d0_y_lo),
    .hsync(d0_hsync), .vsync(d0_vsync), .blank(d0_blank),
    .line_start(d0_line_start), .frame_start(d0_frame_start),
    .fetch(d0_fetch), .frame_cnt(d0_frame_cnt)
  );

  vga_timing_gen #(
    .XH_W(3), .XL_W(3), .YH_W(3), .YL_W(2), .H_ROLL(4), .V_ROLL(2),
    .H_FPORCH(24), .H_SYNC(26), .H_BPORCH(32), .H_NEXT(35),
    .V_FPORCH(8), .V_SYNC(9), .V_BPORCH(12), .V_NEXT(13),
    .HSYNC_POL(1'b0), .VSYNC_POL(1'b1), .FETCH_X(33), .FRAME_W(3)
  ) u_dut_sm (
    .clk(clk), .rst_n(rst_n), .pix_en(pix_en),
    .x_hi(d1_x_hi), .x_lo(d1_x_lo), .y_hi(d1_y_hi), .y_lo(d1_y_lo),
    .hsync(d1_hsync), .vsync(d1_vsync), .blank(d1_blank),
    .line_start(d1_line_start), .frame_start(d1_frame_start),
    .fetch(d1_fetch), .frame_cnt(d1_frame_cnt)
  );

  cfg_t   cfg [2];
  model_t mdl [2];
  int     n_checks = 0;
  int     n_fail   = 0;
  bit     chk_en   = 1'b0;
  bit     saw_wrap = 1'b0;
  int     prev_fc1 = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int ncols(cfg_t c);
    return (c.h_next >> c.xl_w) * (c.h_roll + 1) + (c.h_next & ((1 << c.xl_w) - 1)) + 1;
  endfunction

  function automatic int nrows(cfg_t c);
    return (c.v_next >> c.yl_w) * (c.v_roll + 1) + (c.v_next & ((1 << c.yl_w) - 1)) + 1;
  endfunction

  function automatic int xpos(cfg_t c, int col);
    return ((col / (c.h_roll + 1)) << c.xl_w) + col % (c.h_roll + 1);
  endfunction

  function automatic int ypos(cfg_t c, int row);
    return ((row / (c.v_roll + 1)) << c.yl_w) + row % (c.v_roll + 1);
  endfunction

  function automatic model_t step(cfg_t c, model_t m, bit rst_i, bit en_i);
    model_t n = m;
    int x = xpos(c, m.col);
    int y = ypos(c, m.row);
    if (!rst_i) begin
      n.col = 0; n.row = 0; n.fcnt = 0;
      n.hs = !c.hpol; n.vs = !c.vpol;
      n.ls = 0; n.fs = 0; n.fe = 0;
    end else if (en_i) begin
      n.hs = (x >= c.h_sync && x < c.h_bporch) ? c.hpol : !c.hpol;
      n.vs = (y >= c.v_sync && y < c.v_bporch) ? c.vpol : !c.vpol;
      n.ls = (m.col == ncols(c) - 1) && (y < c.v_fporch);
      n.fs = (m.col == ncols(c) - 1) && (m.row == 0);
      n.fe = (x == c.fetch_x) &&
             (m.row == nrows(c) - 1 || ((y + 1) % (1 << c.yw)) < c.v_fporch);
      if (x == c.h_sync) begin
        if (m.row == nrows(c) - 1) begin
          n.row  = 0;
          n.fcnt = (m.fcnt + 1) % (1 << c.frame_w);
        end else begin
          n.row = m.row + 1;
        end
      end
      n.col = (m.col + 1) % ncols(c);
    end
    return n;
  endfunction

  function automatic int flags(cfg_t c, model_t m);
    bit b = xpos(c, m.col) >= c.h_fporch || ypos(c, m.row) >= c.v_fporch;
    return {26'd0, m.hs, m.vs, b, m.ls, m.fs, m.fe};
  endfunction

  always @(posedge clk)
    for (int i = 0; i < 2; i++) mdl[i] <= step(cfg[i], mdl[i], rst_n, pix_en);

  always @(negedge clk) begin
    if (chk_en) begin
      check("def_x", {d0_x_hi, d0_x_lo}, xpos(cfg[0], mdl[0].col));
      check("def_y", {d0_y_hi, d0_y_lo}, ypos(cfg[0], mdl[0].row));
      check("def_frame_cnt", d0_frame_cnt, mdl[0].fcnt);
      check("def_flags", {d0_hsync, d0_vsync, d0_blank, d0_line_start, d0_frame_start, d0_fetch},
            flags(cfg[0], mdl[0]));
      check("sm_x", {d1_x_hi, d1_x_lo}, xpos(cfg[1], mdl[1].col));
      check("sm_y", {d1_y_hi, d1_y_lo}, ypos(cfg[1], mdl[1].row));
      check("sm_frame_cnt", d1_frame_cnt, mdl[1].fcnt);
      check("sm_flags", {d1_hsync, d1_vsync, d1_blank, d1_line_start, d1_frame_start, d1_fetch},
            flags(cfg[1], mdl[1]));
      if (prev_fc1 == 7 && d1_frame_cnt == 3'd0) saw_wrap = 1'b1;
      prev_fc1 = int'(d1_frame_cnt);
    end
  end

  task automatic drive(input int mode);
    case (mode)
      0:       pix_en = 1'b1;
      1:       pix_en = ~pix_en;
      default: pix_en = ($urandom % 4) != 0;
    endcase
  endtask

  // Cycles between rising edges of the small instance's frame_start, and the
  // number of line_start rises inside that window.
  task automatic measure(input int mode, output int period, output int lines);
    bit prev_fs, prev_ls, found;
    period  = -1;
    lines   = 0;
    prev_fs = d1_frame_start;
    found   = 1'b0;
    for (int i = 0; i < 3000 && !found; i++) begin
      drive(mode);
      @(negedge clk);
      if (d1_frame_start && !prev_fs) found = 1'b1;
      prev_fs = d1_frame_start;
    end
    if (!found) begin
      check("frame_start_timeout", 0, 1);
      return;
    end
    prev_ls = d1_line_start;
    found   = 1'b0;
    for (int i = 1; i <= 3000 && !found; i++) begin
      drive(mode);
      @(negedge clk);
      if (d1_line_start && !prev_ls) lines++;
      prev_ls = d1_line_start;
      if (d1_frame_start && !prev_fs) begin
        found  = 1'b1;
        period = i;
      end
      prev_fs = d1_frame_start;
    end
    if (!found) check("frame_period_timeout", 0, 1);
  endtask

  initial begin
    int hs_cnt, period, lines;
    cfg[0] = '{xl_w: 6, h_roll: 39, h_fporch: 32*64, h_sync: 33*64+8, h_bporch: 34*64,
               h_next: 35*64+39, fetch_x: 35*64+31, yl_w: 6, yw: 11, v_roll: 44,
               v_fporch: 16*64, v_sync: 16*64+3, v_bporch: 16*64+8, v_next: 16*64+20,
               frame_w: 8, hpol: 1'b1, vpol: 1'b0};
    cfg[1] = '{xl_w: 3, h_roll: 4, h_fporch: 24, h_sync: 26, h_bporch: 32, h_next: 35,
               fetch_x: 33, yl_w: 2, yw: 5, v_roll: 2, v_fporch: 8, v_sync: 9,
               v_bporch: 12, v_next: 13, frame_w: 3, hpol: 1'b0, vpol: 1'b1};
    rst_n  = 1'b0;
    pix_en = 1'b0;
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    check("rst_def_x", {d0_x_hi, d0_x_lo}, 0);
    check("rst_def_hsync", d0_hsync, 0);
    check("rst_def_vsync", d0_vsync, 1);
    check("rst_def_blank", d0_blank, 0);
    check("rst_sm_hsync", d1_hsync, 1);
    check("rst_sm_vsync", d1_vsync, 0);

    rst_n  = 1'b1;
    pix_en = 1'b1;
    repeat (39) @(negedge clk);
    check("def_x_39_lo", d0_x_lo, 39);
    @(negedge clk);
    check("def_x_roll_hi", d0_x_hi, 1);
    check("def_x_roll_lo", d0_x_lo, 0);
    hs_cnt = 0;
    repeat (1400) begin
      @(negedge clk);
      if (d0_hsync) hs_cnt++;
    end
    check("def_hsync_width", hs_cnt, 32);
    check("def_line_wrap_x", {d0_x_hi, d0_x_lo}, 0);
    check("def_line_wrap_y_lo", d0_y_lo, 1);
    check("def_line_wrap_blank", d0_blank, 0);

    measure(0, period, lines);
    check("sm_frame_period", period, 264);
    check("sm_active_lines", lines, 6);
    measure(1, period, lines);
    check("sm_frame_period_half_rate", period, 528);
    check("sm_active_lines_half_rate", lines, 6);

    repeat (37) begin
      drive(2);
      @(negedge clk);
    end
    pix_en = 1'b0;
    rst_n  = 1'b0;
    @(negedge clk);
    check("midrst_def_x", {d0_x_hi, d0_x_lo}, 0);
    check("midrst_def_y", {d0_y_hi, d0_y_lo}, 0);
    check("midrst_def_hsync", d0_hsync, 0);
    check("midrst_sm_x", {d1_x_hi, d1_x_lo}, 0);
    check("midrst_sm_frame_cnt", d1_frame_cnt, 0);
    check("midrst_sm_strobes", {d1_line_start, d1_frame_start, d1_fetch}, 0);
    rst_n = 1'b1;

    repeat (6500) begin
      drive(2);
      @(negedge clk);
    end
    check("sm_frame_cnt_wrapped", saw_wrap, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
